mesh_collector: RTL and testbench

Result-drain endpoint for the Nanci sorting mesh. It is the receive side of the mesh edge interface: it accepts words from the mesh's N edge output ports through valid/ready handshakes, arbitrates between ports round-robin, and buffers accepted words in a FIFO. It re-emits them as a single serialized stream and signals `done` once a programmed number of words has been delivered downstream. It sits between the `mesh` top and the host/readback logic, and replaces ad-hoc waveform inspection of mesh outputs.

---
 rtl/nanci_pkg.sv | 19 +
 rtl/mesh_collector_if.sv | 23 ++
 rtl/mesh_fifo.sv | 42 ++++
 rtl/mesh_collector.sv | 140 ++++++++++++++
 tb/tb_mesh_collector.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/nanci_pkg.sv
// Shared definitions for the Nanci mesh readback path: word width,
// collector FSM states and the packed-port slice helper.
package nanci_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DRAIN,
    DONE
  } collector_state_t;

  // Bit offset of port 'port' inside a packed {port N-1, ..., port 0} bus.
  function automatic int unsigned portLsb(input int unsigned port, input int unsigned width);
    return port * width;
  endfunction

endpackage

// File: rtl/mesh_collector_if.sv
// Mesh-edge ingress and serialized egress handshake bundle for mesh_collector.
// The collector uses the slave modport; the mesh/host side uses master.
interface mesh_collector_if #(
  parameter int DATA_W  = nanci_pkg::DATA_W,
  parameter int N_PORTS = 4
);
  logic [N_PORTS-1:0]        in_valid;
  logic [N_PORTS*DATA_W-1:0] in_data;
  logic [N_PORTS-1:0]        in_ready;
  logic                      out_valid;
  logic [DATA_W-1:0]         out_data;
  logic                      out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/mesh_fifo.sv
// Synchronous first-word-fall-through FIFO; the head word is visible on
// data_o in the cycle after it is written, and reads as 0 while empty.
module mesh_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wrPtr_q, rdPtr_q;
  logic              doPush, doPop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty_o = (wrPtr_q == rdPtr_q);
  assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign data_o  = empty_o ? '0 : mem[rdPtr_q[AW-1:0]];
  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
      if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr_q[AW-1:0]] <= data_i;
  end
endmodule

// File: rtl/mesh_collector.sv
// Result-drain endpoint: round-robin collects mesh edge words into a FIFO and
// replays them as one stream. Define MESH_COLLECTOR_ORDER_CHECK_EN for the
// sticky unsigned ordering checker on the output stream.
import nanci_pkg::*;

module mesh_collector #(
  parameter int DATA_W     = nanci_pkg::DATA_W,
  parameter int N_PORTS    = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_W-1:0]      expected_count,
  mesh_collector_if.slave       bus,
  output logic [CNT_W-1:0]      recv_count,
  output logic                  done,
  output logic                  order_err
);
  localparam int PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  collector_state_t  state_q, state_d;
  logic [CNT_W-1:0]  expected_q, expected_d, recv_q, recv_d, sent_q, sent_d;
  logic [PTR_W-1:0]  lastGrant_q, lastGrant_d, grantIdx, candIdx;
  int unsigned       candInt;
  logic              grantFound, fifoFull, fifoEmpty, push, pop, runStart;
  logic [DATA_W-1:0] pushData;

  // Search upward from the port after the last grant, wrapping once around.
  always_comb begin
    grantFound = 1'b0;
    grantIdx   = lastGrant_q;
    candInt    = 0;
    candIdx    = '0;
    for (int i = 1; i <= N_PORTS; i++) begin
      candInt = (32'(lastGrant_q) + 32'(i)) % N_PORTS;
      candIdx = PTR_W'(candInt);
      if (!grantFound && bus.in_valid[candIdx]) begin
        grantFound = 1'b1;
        grantIdx   = candIdx;
      end
    end
  end

  always_comb begin
    bus.in_ready = '0;
    if (state_q == COLLECT && grantFound && !fifoFull) bus.in_ready[grantIdx] = 1'b1;
  end

  assign push          = |(bus.in_ready & bus.in_valid);
  assign pushData      = bus.in_data[portLsb(32'(grantIdx), DATA_W) +: DATA_W];
  assign pop           = bus.out_valid && bus.out_ready;
  assign bus.out_valid = !fifoEmpty;
  assign recv_count    = recv_q;
  assign done          = (state_q == DONE);

  mesh_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (pushData),
    .pop_i   (pop),
    .data_o  (bus.out_data),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  // The FIFO only ever holds this run's words, so sent==expected implies empty.
  always_comb begin
    state_d     = state_q;
    expected_d  = expected_q;
    recv_d      = recv_q;
    lastGrant_d = lastGrant_q;
    runStart    = 1'b0;
    sent_d      = pop ? sent_q + 1'b1 : sent_q;
    if (push) begin
      recv_d      = recv_q + 1'b1;
      lastGrant_d = grantIdx;
    end
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          runStart   = 1'b1;
          expected_d = expected_count;
          recv_d     = '0;
          sent_d     = '0;
          state_d    = (expected_count == '0) ? DONE : COLLECT;
        end
      end
      COLLECT: if (push && recv_d == expected_q) state_d = DRAIN;
      DRAIN:   if (sent_d == expected_q) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      expected_q  <= '0;
      recv_q      <= '0;
      sent_q      <= '0;
      lastGrant_q <= PTR_W'(N_PORTS - 1);
    end else begin
      state_q     <= state_d;
      expected_q  <= expected_d;
      recv_q      <= recv_d;
      sent_q      <= sent_d;
      lastGrant_q <= lastGrant_d;
    end
  end

`ifdef MESH_COLLECTOR_ORDER_CHECK_EN
  logic [DATA_W-1:0] lastWord_q;
  logic              havePrev_q, orderErr_q;

  // First pop of a run only seeds the reference word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lastWord_q <= '0;
      havePrev_q <= 1'b0;
      orderErr_q <= 1'b0;
    end else if (runStart) begin
      havePrev_q <= 1'b0;
      orderErr_q <= 1'b0;
    end else if (pop) begin
      if (havePrev_q && bus.out_data < lastWord_q) orderErr_q <= 1'b1;
      lastWord_q <= bus.out_data;
      havePrev_q <= 1'b1;
    end
  end

  assign order_err = orderErr_q;
`else
  assign order_err = 1'b0;
`endif
endmodule

// File: tb/tb_mesh_collector.sv
// Directed, table-driven bench for mesh_collector (4 ports, 32-bit words,
// 8-deep FIFO); covers MESH_COLLECTOR_ORDER_CHECK_EN both ways.
module tb_mesh_collector;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] expected_count;
  logic [15:0] recv_count;
  logic        done;
  logic        order_err;
  int          total = 0;
  int          passed = 0;

  typedef struct {
    logic [3:0]  inValid;
    logic [3:0]  expReady;
    logic        expOutValid;
    logic [31:0] expOutData;
    logic        expDone;
  } vec_t;

  vec_t vecs [8];

  mesh_collector_if #(.DATA_W(32), .N_PORTS(4)) bus ();

  mesh_collector #(
    .DATA_W     (32),
    .N_PORTS    (4),
    .FIFO_DEPTH (8),
    .CNT_W      (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .expected_count (expected_count),
    .bus            (bus),
    .recv_count     (recv_count),
    .done           (done),
    .order_err      (order_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic [31:0] d0, input logic [31:0] d1,
                               input logic [31:0] d2, input logic [31:0] d3);
    bus.in_valid = v;
    bus.in_data  = {d3, d2, d1, d0};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic startRun(input logic [15:0] cnt);
    start          = 1'b1;
    expected_count = cnt;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acceptIdx;
    int popIdx;
    int cyc;
    logic [31:0] w [4];

    vecs[0] = '{4'b1111, 4'b0001, 1'b1, 32'd100, 1'b0};
    vecs[1] = '{4'b0101, 4'b0100, 1'b1, 32'd112, 1'b0};
    vecs[2] = '{4'b0000, 4'b0000, 1'b0, 32'd0,   1'b0};
    vecs[3] = '{4'b1000, 4'b1000, 1'b1, 32'd133, 1'b0};
    vecs[4] = '{4'b0011, 4'b0001, 1'b1, 32'd140, 1'b0};
    vecs[5] = '{4'b0011, 4'b0010, 1'b1, 32'd151, 1'b0};
    vecs[6] = '{4'b0010, 4'b0010, 1'b1, 32'd161, 1'b0};
    vecs[7] = '{4'b1111, 4'b0000, 1'b0, 32'd0,   1'b1};

    rst            = 1'b1;
    start          = 1'b0;
    expected_count = '0;
    bus.out_ready  = 1'b0;
    applyStimulus(4'b0000, 0, 0, 0, 0);
    #12;
    checkOutput("rst_in_ready", bus.in_ready, 0);
    checkOutput("rst_out_valid", bus.out_valid, 0);
    checkOutput("rst_out_data", bus.out_data, 0);
    checkOutput("rst_recv_count", recv_count, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_order_err", order_err, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // All ports valid: strict 0,1,2,3 rotation, nothing after the 8th word.
    startRun(16'd8);
    bus.out_ready = 1'b1;
    applyStimulus(4'b1111, 300, 301, 302, 303);
    for (int k = 0; k < 9; k++) begin
      #2;
      checkOutput($sformatf("rr_ready%0d", k), bus.in_ready, (k < 8) ? 4'(1 << (k % 4)) : 4'b0000);
      tick();
      if (k < 8) checkOutput($sformatf("rr_data%0d", k), bus.out_data, 300 + (k % 4));
    end
    checkOutput("rr_done", done, 1);
    checkOutput("rr_out_valid", bus.out_valid, 0);

    // Mixed valid patterns from the vector table.
    startRun(16'd6);
    for (int r = 0; r < 8; r++) begin
      applyStimulus(vecs[r].inValid, 100 + r * 10, 101 + r * 10, 102 + r * 10, 103 + r * 10);
      #2;
      checkOutput($sformatf("tbl%0d_ready", r), bus.in_ready, vecs[r].expReady);
      tick();
      checkOutput($sformatf("tbl%0d_out_valid", r), bus.out_valid, vecs[r].expOutValid);
      if (vecs[r].expOutValid) checkOutput($sformatf("tbl%0d_out_data", r), bus.out_data, vecs[r].expOutData);
      checkOutput($sformatf("tbl%0d_done", r), done, vecs[r].expDone);
    end
    checkOutput("tbl_recv_count", recv_count, 6);

    // Port 1 streams 3,5,7,9.
    startRun(16'd4);
    checkOutput("s1_done_falls", done, 0);
    w[0] = 3; w[1] = 5; w[2] = 7; w[3] = 9;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(4'b0010, 0, w[k], 0, 0);
      #2;
      checkOutput($sformatf("s1_ready%0d", k), bus.in_ready, 4'b0010);
      tick();
      checkOutput($sformatf("s1_out_valid%0d", k), bus.out_valid, 1);
      checkOutput($sformatf("s1_out_data%0d", k), bus.out_data, w[k]);
    end
    applyStimulus(4'b0000, 0, 0, 0, 0);
    tick();
    checkOutput("s1_done", done, 1);
    checkOutput("s1_recv_count", recv_count, 4);

    // Downstream stalled: FIFO fills at 8, then drains all 12 in order.
    startRun(16'd12);
    bus.out_ready = 1'b0;
    acceptIdx = 0;
    for (int k = 0; k < 10; k++) begin
      applyStimulus(4'b1111, 200 + acceptIdx, 200 + acceptIdx, 200 + acceptIdx, 200 + acceptIdx);
      #2;
      checkOutput($sformatf("full_onehot%0d", k), $onehot0(bus.in_ready), 1);
      if (bus.in_ready != 0) acceptIdx++;
      tick();
    end
    checkOutput("full_accepts", acceptIdx, 8);
    #1;
    checkOutput("full_ready_low", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    popIdx = 0;
    cyc = 0;
    while (!done && cyc < 100) begin
      applyStimulus(4'b1111, 200 + acceptIdx, 200 + acceptIdx, 200 + acceptIdx, 200 + acceptIdx);
      #1;
      if (bus.in_ready != 0) acceptIdx++;
      if (bus.out_valid) begin
        checkOutput($sformatf("full_pop%0d", popIdx), bus.out_data, 200 + popIdx);
        popIdx++;
      end
      tick();
      cyc++;
    end
    checkOutput("full_pops", popIdx, 12);
    checkOutput("full_total_accepts", acceptIdx, 12);
    checkOutput("full_done", done, 1);
    checkOutput("full_recv_count", recv_count, 12);

    // Zero-length run completes immediately and never grants.
    startRun(16'd0);
    checkOutput("zero_done", done, 1);
    applyStimulus(4'b1111, 1, 2, 3, 4);
    for (int k = 0; k < 3; k++) begin
      #2;
      checkOutput($sformatf("zero_ready%0d", k), bus.in_ready, 0);
      tick();
    end

    // Out-of-order stream 2,9,4 through different ports.
    startRun(16'd3);
    applyStimulus(4'b0001, 2, 0, 0, 0);
    tick();
    applyStimulus(4'b0100, 0, 0, 9, 0);
    tick();
    applyStimulus(4'b0010, 0, 4, 0, 0);
    tick();
    checkOutput("ord_no_err_yet", order_err, 0);
    applyStimulus(4'b0000, 0, 0, 0, 0);
    tick();
`ifdef MESH_COLLECTOR_ORDER_CHECK_EN
    checkOutput("ord_err_set", order_err, 1);
    tick();
    checkOutput("ord_err_held", order_err, 1);
`else
    checkOutput("ord_err_tied", order_err, 0);
    tick();
`endif
    checkOutput("ord_done", done, 1);
    startRun(16'd1);
    checkOutput("ord_err_cleared", order_err, 0);
    applyStimulus(4'b0001, 1, 0, 0, 0);
    tick();
    applyStimulus(4'b0000, 0, 0, 0, 0);
    tick();
    checkOutput("ord_rerun_done", done, 1);

    // Asynchronous reset mid-collect with three buffered words.
    startRun(16'd10);
    bus.out_ready = 1'b0;
    applyStimulus(4'b0001, 50, 0, 0, 0);
    tick();
    tick();
    tick();
    checkOutput("arst_pre_count", recv_count, 3);
    applyStimulus(4'b0000, 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_out_valid", bus.out_valid, 0);
    checkOutput("arst_recv_count", recv_count, 0);
    checkOutput("arst_done", done, 0);
    checkOutput("arst_in_ready", bus.in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    startRun(16'd2);
    bus.out_ready = 1'b1;
    applyStimulus(4'b0100, 0, 0, 77, 0);
    tick();
    checkOutput("arst_word0", bus.out_data, 77);
    applyStimulus(4'b0100, 0, 0, 88, 0);
    tick();
    checkOutput("arst_word1", bus.out_data, 88);
    applyStimulus(4'b0000, 0, 0, 0, 0);
    tick();
    checkOutput("arst_rerun_done", done, 1);
    checkOutput("arst_rerun_count", recv_count, 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
